// File: rtl/regfile_sequencer_if.sv
// Instruction-side handshake between an instruction source and the register-file sequencer.
// The source is the master: it offers instructions and observes retire status.
interface regfile_sequencer_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic        done;
  logic [7:0]  result;
  logic        flag_z;
  logic        flag_c;

  modport master (
    output instr_valid,
    output instr,
    input  instr_ready,
    input  done,
    input  result,
    input  flag_z,
    input  flag_c
  );

  modport slave (
    input  instr_valid,
    input  instr,
    output instr_ready,
    output done,
    output result,
    output flag_z,
    output flag_c
  );
endinterface

// File: rtl/regfile_sequencer.sv
// Controller for a 16 x 8-bit register file with one always-writing port and two asynchronous
// read ports. Zero-clears the file after reset, then executes 16-bit register-to-register
// instructions in three cycles each (accept, read, write).
module regfile_sequencer #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  regfile_sequencer_if.slave  bus,
  output logic [3:0]          rf_sel_in,
  output logic [7:0]          rf_in,
  output logic [3:0]          rf_sel_o1,
  output logic [3:0]          rf_sel_o2,
  input  logic [7:0]          rf_o1,
  input  logic [7:0]          rf_o2
);

  typedef enum logic [1:0] {StClear, StIdle, StRead, StWrite} state_e;

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpShl = 4'd5;
  localparam logic [3:0] OpShr = 4'd6;
  localparam logic [3:0] OpMov = 4'd7;
  localparam logic [3:0] OpLdi = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;

  state_e      state_q;
  logic [3:0]  clr_cnt_q;
  logic [15:0] instr_q;
  logic [7:0]  pend_res_q;
  logic        pend_c_q;
  logic        done_q;
  logic [7:0]  result_q;
  logic        flag_z_q;
  logic        flag_c_q;

  // Field decode of the latched instruction.
  logic [3:0] op;
  logic [3:0] rd;
  logic [3:0] rs1;
  logic [3:0] rs2;
  logic [7:0] imm8;
  logic       writes_rf;
  logic       updates_flags;

  assign op            = instr_q[15:12];
  assign rd            = instr_q[11:8];
  assign rs1           = instr_q[7:4];
  assign rs2           = instr_q[3:0];
  assign imm8          = instr_q[7:0];
  // Opcodes 0..8 write rd; CMP (9) only updates result/flags; 10..15 are NOPs.
  assign writes_rf     = (op <= OpLdi);
  assign updates_flags = (op <= OpCmp);

  // ALU on the live read-port data; consumed only at the end of the READ cycle.
  logic [7:0] alu_res;
  logic       alu_c;
  logic [8:0] sum9;
  logic [8:0] diff9;

  assign sum9  = {1'b0, rf_o1} + {1'b0, rf_o2};
  assign diff9 = {1'b0, rf_o1} - {1'b0, rf_o2};

  // Combinational ALU: result and carry/borrow for the current opcode.
  always_comb begin
    alu_res = 8'h00;
    alu_c   = 1'b0;
    case (op)
      OpAdd: begin
        alu_res = sum9[7:0];
        alu_c   = sum9[8];
      end
      OpSub, OpCmp: begin
        alu_res = diff9[7:0];
        alu_c   = diff9[8];  // borrow out means rf_o1 < rf_o2
      end
      OpAnd:   alu_res = rf_o1 & rf_o2;
      OpOr:    alu_res = rf_o1 | rf_o2;
      OpXor:   alu_res = rf_o1 ^ rf_o2;
      OpShl:   alu_res = rf_o1 << rf_o2[2:0];
      OpShr:   alu_res = rf_o1 >> rf_o2[2:0];
      OpMov:   alu_res = rf_o1;
      OpLdi:   alu_res = imm8;
      default: begin
        alu_res = 8'h00;
        alu_c   = 1'b0;
      end
    endcase
  end

  // Sequencer FSM with registered retire status and result/flag outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR_ON_RESET ? StClear : StIdle;
      clr_cnt_q <= 4'd0;
      done_q    <= 1'b0;
      result_q  <= 8'h00;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StClear: begin
          clr_cnt_q <= clr_cnt_q + 4'd1;
          if (clr_cnt_q == 4'd15) begin
            state_q <= StIdle;
          end
        end
        StIdle: begin
          // Ready is implied by being in IDLE, so valid alone completes the handshake.
          if (bus.instr_valid) begin
            instr_q <= bus.instr;
            state_q <= StRead;
          end
        end
        StRead: begin
          // Operands are captured here, so rd aliasing rs1/rs2 sees the old values.
          pend_res_q <= alu_res;
          pend_c_q   <= alu_c;
          state_q    <= StWrite;
        end
        StWrite: begin
          done_q  <= 1'b1;
          state_q <= StIdle;
          if (updates_flags) begin
            result_q <= pend_res_q;
            flag_z_q <= (pend_res_q == 8'h00);
            flag_c_q <= pend_c_q;
          end
        end
      endcase
    end
  end

  // Register-file port drive; any cycle without a real write rewrites read port 1's entry.
  always_comb begin
    logic hold;
    hold      = 1'b1;
    rf_sel_o1 = 4'd0;
    rf_sel_o2 = 4'd0;
    rf_sel_in = 4'd0;
    rf_in     = 8'h00;
    unique case (state_q)
      StClear: begin
        hold      = 1'b0;
        rf_sel_in = clr_cnt_q;
        rf_in     = 8'h00;
      end
      StIdle: begin
        hold = 1'b1;
      end
      StRead: begin
        rf_sel_o1 = rs1;
        rf_sel_o2 = rs2;
      end
      StWrite: begin
        if (writes_rf) begin
          hold      = 1'b0;
          rf_sel_in = rd;
          rf_in     = pend_res_q;
        end else begin
          rf_sel_o1 = rd;
        end
      end
    endcase
    if (hold) begin
      rf_sel_in = rf_sel_o1;
      rf_in     = rf_o1;
    end
  end

  assign bus.instr_ready = (state_q == StIdle);
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.flag_z      = flag_z_q;
  assign bus.flag_c      = flag_c_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: a behavioural register file drives the DUT's read
// ports, and an instruction-level reference model predicts port activity, retire status and
// register contents.
module tb_regfile_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_sequencer_if bus ();

  logic [3:0] rf_sel_in;
  logic [7:0] rf_in;
  logic [3:0] rf_sel_o1;
  logic [3:0] rf_sel_o2;
  logic [7:0] rf_o1;
  logic [7:0] rf_o2;

  // Register file: writes every posedge, asynchronous reads.
  logic [7:0] rf_mem [16];
  assign rf_o1 = rf_mem[rf_sel_o1];
  assign rf_o2 = rf_mem[rf_sel_o2];
  always @(posedge clk) rf_mem[rf_sel_in] <= rf_in;

  regfile_sequencer #(
    .CLEAR_ON_RESET(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .rf_sel_in (rf_sel_in),
    .rf_in     (rf_in),
    .rf_sel_o1 (rf_sel_o1),
    .rf_sel_o2 (rf_sel_o2),
    .rf_o1     (rf_o1),
    .rf_o2     (rf_o2)
  );

  int errors = 0;
  int checks = 0;

  // Reference state.
  logic [7:0] exp_rf [16];
  logic [7:0] exp_result;
  logic       exp_z;
  logic       exp_c;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction semantics from plain integer arithmetic.
  function automatic void model(input logic [15:0] ins, output logic [7:0] res,
                                output logic c, output bit wr, output bit upd);
    int op;
    int a;
    int b;
    int s;
    op  = int'(ins[15:12]);
    a   = int'(exp_rf[ins[7:4]]);
    b   = int'(exp_rf[ins[3:0]]);
    res = 8'h00;
    c   = 1'b0;
    case (op)
      0: begin s = a + b; res = 8'(s % 256); c = (s >= 256); end
      1, 9: begin s = a - b + 256; res = 8'(s % 256); c = (a < b); end
      2: res = 8'(a & b);
      3: res = 8'(a | b);
      4: res = 8'(a ^ b);
      5: res = 8'((a * (1 << (b % 8))) % 256);
      6: res = 8'(a / (1 << (b % 8)));
      7: res = 8'(a);
      8: res = ins[7:0];
      default: res = 8'h00;
    endcase
    wr  = (op <= 8);
    upd = (op <= 9);
  endfunction

  task automatic compare_rf(input string tag);
    for (int i = 0; i < 16; i++) check(tag, 16'(rf_mem[i]), 16'(exp_rf[i]));
  endtask

  // Entered at a negedge with rst just released and the DUT in its first clear cycle.
  task automatic run_clear();
    for (int i = 0; i < 16; i++) begin
      check("clr_ready", 16'(bus.instr_ready), 16'd0);
      check("clr_done", 16'(bus.done), 16'd0);
      check("clr_sel_in", 16'(rf_sel_in), 16'(i));
      check("clr_rf_in", 16'(rf_in), 16'h00);
      @(negedge clk);
    end
    check("post_clr_ready", 16'(bus.instr_ready), 16'd1);
    check("post_clr_result", 16'(bus.result), 16'h00);
    check("post_clr_z", 16'(bus.flag_z), 16'd0);
    check("post_clr_c", 16'(bus.flag_c), 16'd0);
    for (int i = 0; i < 16; i++) exp_rf[i] = 8'h00;
    exp_result = 8'h00;
    exp_z      = 1'b0;
    exp_c      = 1'b0;
    compare_rf("post_clr_rf");
  endtask

  // Issue one instruction from an IDLE negedge and follow it to its retire cycle.
  task automatic exec(input logic [15:0] ins, input bit keep_valid);
    logic [7:0] res;
    logic       c;
    bit         wr;
    bit         upd;
    logic [3:0] rd;
    logic [3:0] rs1;
    logic [3:0] rs2;
    rd  = ins[11:8];
    rs1 = ins[7:4];
    rs2 = ins[3:0];
    model(ins, res, c, wr, upd);
    check("idle_ready", 16'(bus.instr_ready), 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = ins;
    @(negedge clk);
    check("read_ready", 16'(bus.instr_ready), 16'd0);
    check("read_done", 16'(bus.done), 16'd0);
    check("read_sel_o1", 16'(rf_sel_o1), 16'(rs1));
    check("read_sel_o2", 16'(rf_sel_o2), 16'(rs2));
    check("read_hold_sel", 16'(rf_sel_in), 16'(rs1));
    check("read_hold_data", 16'(rf_in), 16'(exp_rf[rs1]));
    if (!keep_valid) bus.instr_valid = 1'b0;
    @(negedge clk);
    check("write_ready", 16'(bus.instr_ready), 16'd0);
    check("write_done", 16'(bus.done), 16'd0);
    check("write_sel_in", 16'(rf_sel_in), 16'(rd));
    if (wr) begin
      check("write_data", 16'(rf_in), 16'(res));
    end else begin
      check("write_hold_sel_o1", 16'(rf_sel_o1), 16'(rd));
      check("write_hold_data", 16'(rf_in), 16'(exp_rf[rd]));
    end
    if (wr) exp_rf[rd] = res;
    if (upd) begin
      exp_result = res;
      exp_z      = (res == 8'h00);
      exp_c      = c;
    end
    @(negedge clk);
    check("retire_done", 16'(bus.done), 16'd1);
    check("retire_ready", 16'(bus.instr_ready), 16'd1);
    check("retire_result", 16'(bus.result), 16'(exp_result));
    check("retire_z", 16'(bus.flag_z), 16'(exp_z));
    check("retire_c", 16'(bus.flag_c), 16'(exp_c));
    compare_rf("retire_rf");
  endtask

  // Idle cycles with valid low: hold writes on entry 0, no retire pulse.
  task automatic idle_gap(input int n);
    bus.instr_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("gap_done", 16'(bus.done), 16'd0);
      check("gap_ready", 16'(bus.instr_ready), 16'd1);
      check("gap_hold_sel", 16'(rf_sel_in), 16'd0);
      check("gap_hold_data", 16'(rf_in), 16'(exp_rf[0]));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    rst             = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_clear();

    // LDI r1, 0x5A
    exec(16'h815A, 1'b0);
    check("ldi_result", 16'(bus.result), 16'h5A);
    check("ldi_r1", 16'(rf_mem[1]), 16'h5A);

    // Back-to-back with valid held high.
    exec(16'h82F0, 1'b1);
    exec(16'h8320, 1'b1);
    exec(16'h0423, 1'b0);
    check("add_result", 16'(bus.result), 16'h10);
    check("add_c", 16'(bus.flag_c), 16'd1);
    check("add_z", 16'(bus.flag_z), 16'd0);
    check("add_r4", 16'(rf_mem[4]), 16'h10);
    idle_gap(1);

    exec(16'h1533, 1'b0);
    check("sub_zero_result", 16'(bus.result), 16'h00);
    check("sub_zero_z", 16'(bus.flag_z), 16'd1);
    check("sub_zero_c", 16'(bus.flag_c), 16'd0);
    exec(16'h1632, 1'b0);
    check("sub_borrow_result", 16'(bus.result), 16'h30);
    check("sub_borrow_c", 16'(bus.flag_c), 16'd1);
    exec(16'h9123, 1'b0);
    check("cmp_result", 16'(bus.result), 16'hD0);
    check("cmp_z", 16'(bus.flag_z), 16'd0);
    check("cmp_c", 16'(bus.flag_c), 16'd0);
    check("cmp_r1_kept", 16'(rf_mem[1]), 16'h5A);

    exec(16'hF000, 1'b0);
    check("nop_result", 16'(bus.result), 16'hD0);

    // Aliased destination: ADD r2, r2, r2 uses the old r2.
    exec(16'h0222, 1'b0);

    // Random instructions over all opcodes.
    for (int i = 0; i < 40; i++) begin
      exec(16'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle_gap(int'($urandom_range(1, 3)));
    end

    // Random non-writing sequences: nothing in the file may change.
    for (int i = 0; i < 20; i++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(10, 15));
      exec({op, 12'($urandom)}, 1'($urandom_range(0, 1)));
      idle_gap(int'($urandom_range(0, 2)));
    end

    // Reset in the READ cycle of an ADD.
    idle_gap(1);
    exec(16'h82F0, 1'b0);
    exec(16'h8320, 1'b0);
    exec(16'h8477, 1'b0);
    check("pre_rst_ready", 16'(bus.instr_ready), 16'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = 16'h0423;
    @(negedge clk);
    check("rst_read_sel_o1", 16'(rf_sel_o1), 16'd2);
    rst             = 1'b1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check("rst_no_done", 16'(bus.done), 16'd0);
    check("rst_r4_unwritten", 16'(rf_mem[4]), 16'h77);
    run_clear();
    idle_gap(3);

    exec(16'h815A, 1'b0);
    check("final_ldi_result", 16'(bus.result), 16'h5A);
    idle_gap(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
